// File: rtl/rle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rle_pkg
//  Description : Shared state encoding, width helper and run-pair type for
//                the run-length compressor and its decompressor peer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rle_pkg;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_SCAN_ENC  = 2'd1;
    localparam logic [1:0] ST_FLUSH_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE_ENC,
        SCAN  = ST_SCAN_ENC,
        FLUSH = ST_FLUSH_ENC
    } state_t;

    // Widest run-length field any instance may need; instances narrow it.
    localparam int RUN_VALUE_W = 16;

    function automatic int rle_cw(input int n);
        return $clog2(n) + 1;
    endfunction

    typedef struct packed {
        logic                   run_bit;
        logic [RUN_VALUE_W-1:0] value;
    } run_pair_t;

endpackage
`default_nettype wire

// File: rtl/rle_compressor_if.sv
`default_nettype none
// ============================================================================
//  Module      : rle_compressor_if
//  Description : Word-in / run-out handshake bundle for the RLE compressor.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rle_compressor_if #(
    parameter int N = 32
);
    localparam int CW = rle_pkg::rle_cw(N);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_word;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic          out_bit;
    logic [CW-1:0] out_value;
    logic          done;

    modport slave (
        input  in_valid, in_word, flush, out_ready,
        output in_ready, out_valid, out_bit, out_value, done
    );

    modport master (
        output in_valid, in_word, flush, out_ready,
        input  in_ready, out_valid, out_bit, out_value, done
    );
endinterface
`default_nettype wire

// File: rtl/rle_out_slot.sv
`default_nettype none
// ============================================================================
//  Module      : rle_out_slot
//  Description : One-entry valid/ready holding register; a new run may be
//                loaded in the same cycle the held one is taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module rle_out_slot
    import rle_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      reset,
    input  wire logic      load,
    input  wire run_pair_t load_data,
    input  wire logic      out_ready,
    output logic           out_valid,
    output run_pair_t      data,
    output logic           free
);
    logic      r_valid;
    run_pair_t r_data;

    assign free      = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign data      = r_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= load_data;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/rle_compressor.sv
`default_nettype none
// ============================================================================
//  Module      : rle_compressor
//  Description : LSB-first run-length encoder; runs merge across words and
//                are capped at N bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module rle_compressor
    import rle_pkg::*;
#(
    parameter int N = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    rle_compressor_if.slave   bus
);
    localparam int CW    = rle_cw(N);
    localparam int IDX_W = $clog2(N);

    state_t           r_state;
    logic             r_in_ready;
    logic             r_done;
    logic [N-1:0]     r_word;
    logic [IDX_W-1:0] r_idx;
    logic             r_run_bit;
    logic [CW-1:0]    r_run_len;

    logic      w_bit;
    logic      w_extend;
    logic      w_emit;
    logic      w_stall;
    logic      w_load;
    logic      w_slot_free;
    logic      w_slot_valid;
    logic      w_unused_value;
    run_pair_t w_load_data;
    run_pair_t w_slot_data;

    assign w_bit    = r_word[r_idx];
    assign w_extend = (r_run_len != '0) && (w_bit == r_run_bit) && (r_run_len < CW'(N));
    assign w_emit   = (r_state == SCAN) && (r_run_len != '0) && !w_extend;
    assign w_stall  = w_emit && !w_slot_free;
    assign w_load   = (w_emit && w_slot_free) ||
                      ((r_state == FLUSH) && (r_run_len != '0) && w_slot_free);

    assign w_load_data.run_bit = r_run_bit;
    assign w_load_data.value   = RUN_VALUE_W'(r_run_len);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
            r_done     <= 1'b0;
            r_word     <= '0;
            r_idx      <= '0;
            r_run_bit  <= 1'b0;
            r_run_len  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_word     <= bus.in_word;
                        r_idx      <= '0;
                        r_state    <= SCAN;
                        r_in_ready <= 1'b0;
                    // Flush is a level; ignore it while done is still showing.
                    end else if (bus.flush && !r_done) begin
                        r_state    <= FLUSH;
                        r_in_ready <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!w_stall) begin
                        r_run_bit <= w_bit;
                        r_run_len <= w_extend ? r_run_len + CW'(1) : CW'(1);
                        if (r_idx == IDX_W'(N - 1)) begin
                            r_idx      <= '0;
                            r_state    <= IDLE;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    if ((r_run_len == '0) || w_slot_free) begin
                        r_run_len  <= '0;
                        r_done     <= 1'b1;
                        r_state    <= IDLE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    rle_out_slot u_out_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load),
        .load_data (w_load_data),
        .out_ready (bus.out_ready),
        .out_valid (w_slot_valid),
        .data      (w_slot_data),
        .free      (w_slot_free)
    );

    assign w_unused_value = ^w_slot_data.value;
    assign bus.in_ready   = r_in_ready;
    assign bus.done       = r_done;
    assign bus.out_valid  = w_slot_valid;
    assign bus.out_bit    = w_slot_data.run_bit;
    assign bus.out_value  = CW'(w_slot_data.value);
endmodule
`default_nettype wire

// File: tb/tb_rle_compressor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rle_compressor
//  Description : Directed self-checking bench for rle_compressor at N=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rle_compressor;
    localparam int N = 8;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    logic [4:0] pair_q [$];
    logic [4:0] exp_q  [$];
    logic       exp_bits [$];
    int         words;

    rle_compressor_if #(.N(N)) bus ();

    rle_compressor #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready)
            pair_q.push_back({bus.out_bit, bus.out_value});
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [N-1:0] w);
        int b;
        b = 0;
        while (!bus.in_ready && b < 100) begin
            step();
            b++;
        end
        chk("in_ready_wait", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_word  = w;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < N; i++) exp_bits.push_back(w[i]);
        words++;
    endtask

    task automatic do_flush(output int cycles);
        bus.flush = 1'b1;
        cycles = 0;
        while (!bus.done && cycles < 200) begin
            step();
            cycles++;
        end
        bus.flush = 1'b0;
        chk("done_seen", bus.done, 1);
        step();
        chk("done_pulse_end", bus.done, 0);
        step();
        step();
    endtask

    task automatic expect_pairs(input string tag);
        logic dec [$];
        int   sum;
        int   diffs;
        chk({tag, "_count"}, pair_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < pair_q.size())
                chk($sformatf("%s_pair%0d", tag, i), pair_q[i], exp_q[i]);
        sum = 0;
        foreach (pair_q[i]) begin
            sum += int'(pair_q[i][3:0]);
            for (int k = 0; k < int'(pair_q[i][3:0]); k++) dec.push_back(pair_q[i][4]);
        end
        chk({tag, "_sum"}, sum, N * words);
        diffs = 0;
        foreach (exp_bits[i])
            if (i >= dec.size() || dec[i] !== exp_bits[i]) diffs++;
        chk({tag, "_decode_diffs"}, diffs, 0);
        pair_q.delete();
        exp_q.delete();
        exp_bits.delete();
        words = 0;
    endtask

    initial begin
        int c;
        n_vec = 0;
        n_err = 0;
        words = 0;
        reset = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_bit", bus.out_bit, 0);
        chk("rst_out_value", bus.out_value, 0);
        chk("rst_done", bus.done, 0);
        reset = 1'b1;
        step();

        // 0x0F: two runs of four, in_ready low for one word time
        send_word(8'h0F);
        c = 0;
        while (!bus.in_ready && c < 100) begin
            step();
            c++;
        end
        chk("t1_busy_cycles", c, 8);
        do_flush(c);
        exp_q.push_back({1'b1, 4'd4});
        exp_q.push_back({1'b0, 4'd4});
        expect_pairs("t1");

        // Flush with nothing pending
        do_flush(c);
        chk("t6_done_latency", c, 2);
        chk("t6_out_valid", bus.out_valid, 0);
        expect_pairs("t6");

        send_word(8'hFF);
        send_word(8'hFF);
        do_flush(c);
        exp_q.push_back({1'b1, 4'd8});
        exp_q.push_back({1'b1, 4'd8});
        expect_pairs("t2");

        send_word(8'hF0);
        send_word(8'h0F);
        do_flush(c);
        exp_q.push_back({1'b0, 4'd4});
        exp_q.push_back({1'b1, 4'd8});
        exp_q.push_back({1'b0, 4'd4});
        expect_pairs("t3");

        // Back-pressure: scan must stall on the second run
        bus.out_ready = 1'b0;
        send_word(8'hAA);
        for (int i = 0; i < 5; i++) step();
        chk("t4_stall_in_ready", bus.in_ready, 0);
        chk("t4_held_valid", bus.out_valid, 1);
        chk("t4_held_bit", bus.out_bit, 0);
        chk("t4_held_value", bus.out_value, 1);
        bus.out_ready = 1'b1;
        do_flush(c);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, 4'd1});
            exp_q.push_back({1'b1, 4'd1});
        end
        expect_pairs("t4");

        // Reset partway through a word discards everything
        send_word(8'h0F);
        step();
        step();
        step();
        reset = 1'b0;
        #1;
        chk("t5_in_ready", bus.in_ready, 1);
        chk("t5_out_valid", bus.out_valid, 0);
        chk("t5_out_value", bus.out_value, 0);
        chk("t5_done", bus.done, 0);
        pair_q.delete();
        exp_bits.delete();
        words = 0;
        step();
        reset = 1'b1;
        step();
        send_word(8'h00);
        do_flush(c);
        exp_q.push_back({1'b0, 4'd8});
        expect_pairs("t5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
